// File: rtl/uart_transmitter_controller_if.sv
// Handshake bundle between the system controller, the UART transmitter and
// uart_transmitter_controller. The master modport is the controller's view and
// the slave modport is the view of whatever surrounds it.
interface uart_transmitter_controller_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                    enable;
  logic [2*DATA_WIDTH-1:0] ALU_result;
  logic                    ALU_result_valid;
  logic [DATA_WIDTH-1:0]   read_data;
  logic                    read_data_valid;
  logic                    transmitter_busy_synchronized;
  logic [DATA_WIDTH-1:0]   transmitter_parallel_data;
  logic                    transmitter_parallel_data_valid;
  logic                    controller_busy;
  logic                    overrun;

  modport master (
    input  enable,
    input  ALU_result,
    input  ALU_result_valid,
    input  read_data,
    input  read_data_valid,
    input  transmitter_busy_synchronized,
    output transmitter_parallel_data,
    output transmitter_parallel_data_valid,
    output controller_busy,
    output overrun
  );

  modport slave (
    output enable,
    output ALU_result,
    output ALU_result_valid,
    output read_data,
    output read_data_valid,
    output transmitter_busy_synchronized,
    input  transmitter_parallel_data,
    input  transmitter_parallel_data_valid,
    input  controller_busy,
    input  overrun
  );
endinterface

// File: rtl/uart_transmitter_controller.sv
// Transmit-side sequencer for the UART. Buffers one register-file byte and one
// ALU result, arbitrates (read data first) and feeds the transmitter one byte at
// a time with a valid/busy handshake. ALU results go low byte first.
// Optional feature macro: UART_TX_CTRL_ACK_TIMEOUT_EN -- abandons an item whose
// byte is not acknowledged within ACK_TIMEOUT_CYCLES cycles.
module uart_transmitter_controller #(
  parameter int unsigned DATA_WIDTH         = 8,
  parameter int unsigned ACK_TIMEOUT_CYCLES = 64
) (
  input logic                           clk,
  input logic                           reset,
  uart_transmitter_controller_if.master bus
);

  localparam int unsigned ItemWidth = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {StIdle, StLoad, StWaitAck, StWaitDone} state_e;

  if (ACK_TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("ACK_TIMEOUT_CYCLES must be nonzero");
  end

  state_e                state_q;
  logic                  src_alu_q;   // item in flight came from the ALU buffer
  logic                  byte_idx_q;  // 0: low byte, 1: high byte
  logic [ItemWidth-1:0]  item_q;      // frozen copy of the item being sent
  logic [DATA_WIDTH-1:0] tx_data_q;
  logic                  tx_valid_q;
  logic                  ctrl_busy_q;
  logic                  overrun_q;

  logic [DATA_WIDTH-1:0] rd_buf_q;
  logic [ItemWidth-1:0]  alu_buf_q;
  logic                  rd_full_q, rd_full_d;
  logic                  alu_full_q, alu_full_d;
  // Set when a buffer is rewritten while its previous contents are in flight,
  // so the flag must survive completion and the new value goes out next.
  logic                  rd_reload_q, rd_reload_d;
  logic                  alu_reload_q, alu_reload_d;

  logic rd_load, alu_load, start, last_byte, item_done, item_abort;
  logic rd_in_flight, alu_in_flight, rd_finish, alu_finish;

  assign rd_load   = bus.enable & bus.read_data_valid;
  assign alu_load  = bus.enable & bus.ALU_result_valid;
  assign start     = (state_q == StIdle) & bus.enable & (rd_full_q | alu_full_q);
  assign last_byte = ~src_alu_q | byte_idx_q;
  assign item_done = (state_q == StWaitDone) & ~bus.transmitter_busy_synchronized & last_byte;

`ifdef UART_TX_CTRL_ACK_TIMEOUT_EN
  localparam int unsigned CntWidth = $clog2(ACK_TIMEOUT_CYCLES + 1);
  logic [CntWidth-1:0] ack_cnt_q;

  assign item_abort = (state_q == StWaitAck) & ~bus.transmitter_busy_synchronized &
                      (ack_cnt_q == CntWidth'(ACK_TIMEOUT_CYCLES - 1));
`else
  assign item_abort = 1'b0;
`endif

  // A source counts as in flight from the cycle it is selected onwards.
  assign rd_in_flight  = ((state_q != StIdle) & ~src_alu_q) | (start & rd_full_q);
  assign alu_in_flight = ((state_q != StIdle) & src_alu_q) | (start & ~rd_full_q);
  assign rd_finish     = (item_done | item_abort) & ~src_alu_q;
  assign alu_finish    = (item_done | item_abort) & src_alu_q;

  // Next state of the full/reload flags; a fresh load always wins.
  always_comb begin
    rd_full_d    = rd_full_q;
    alu_full_d   = alu_full_q;
    rd_reload_d  = rd_reload_q;
    alu_reload_d = alu_reload_q;
    if (start) begin
      rd_reload_d  = 1'b0;
      alu_reload_d = 1'b0;
    end
    if (rd_finish) begin
      rd_full_d   = item_done & rd_reload_q;
      rd_reload_d = 1'b0;
    end
    if (alu_finish) begin
      alu_full_d   = item_done & alu_reload_q;
      alu_reload_d = 1'b0;
    end
    if (rd_load) begin
      rd_full_d   = 1'b1;
      rd_reload_d = rd_in_flight & ~rd_finish;
    end
    if (alu_load) begin
      alu_full_d   = 1'b1;
      alu_reload_d = alu_in_flight & ~alu_finish;
    end
  end

  // Input buffers, flags and the overrun pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_buf_q     <= '0;
      alu_buf_q    <= '0;
      rd_full_q    <= 1'b0;
      alu_full_q   <= 1'b0;
      rd_reload_q  <= 1'b0;
      alu_reload_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      rd_full_q    <= rd_full_d;
      alu_full_q   <= alu_full_d;
      rd_reload_q  <= rd_reload_d;
      alu_reload_q <= alu_reload_d;
      overrun_q    <= (rd_load & rd_full_q) | (alu_load & alu_full_q);
      if (rd_load) rd_buf_q <= bus.read_data;
      if (alu_load) alu_buf_q <= bus.ALU_result;
    end
  end

  // Transfer FSM with registered transmitter outputs and controller_busy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      src_alu_q   <= 1'b0;
      byte_idx_q  <= 1'b0;
      item_q      <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      ctrl_busy_q <= 1'b0;
`ifdef UART_TX_CTRL_ACK_TIMEOUT_EN
      ack_cnt_q   <= '0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            src_alu_q   <= ~rd_full_q;
            byte_idx_q  <= 1'b0;
            item_q      <= rd_full_q ? {{DATA_WIDTH{1'b0}}, rd_buf_q} : alu_buf_q;
            state_q     <= StLoad;
            ctrl_busy_q <= 1'b1;
          end else begin
            ctrl_busy_q <= rd_full_d | alu_full_d;
          end
        end
        StLoad: begin
          tx_data_q   <= byte_idx_q ? item_q[ItemWidth-1:DATA_WIDTH] : item_q[DATA_WIDTH-1:0];
          tx_valid_q  <= 1'b1;
          state_q     <= StWaitAck;
          ctrl_busy_q <= 1'b1;
`ifdef UART_TX_CTRL_ACK_TIMEOUT_EN
          ack_cnt_q   <= '0;
`endif
        end
        StWaitAck: begin
          if (bus.transmitter_busy_synchronized) begin
            tx_valid_q <= 1'b0;
            state_q    <= StWaitDone;
          end
`ifdef UART_TX_CTRL_ACK_TIMEOUT_EN
          else if (item_abort) begin
            tx_valid_q  <= 1'b0;
            state_q     <= StIdle;
            ctrl_busy_q <= rd_full_d | alu_full_d;
          end else begin
            ack_cnt_q <= ack_cnt_q + 1'b1;
          end
`endif
        end
        StWaitDone: begin
          if (!bus.transmitter_busy_synchronized) begin
            if (!last_byte) begin
              byte_idx_q <= 1'b1;
              state_q    <= StLoad;
            end else begin
              state_q     <= StIdle;
              ctrl_busy_q <= rd_full_d | alu_full_d;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.transmitter_parallel_data       = tx_data_q;
  assign bus.transmitter_parallel_data_valid = tx_valid_q;
  assign bus.controller_busy                 = ctrl_busy_q;
  assign bus.overrun                         = overrun_q;

endmodule

// File: tb/tb_uart_transmitter_controller.sv
// Bench for uart_transmitter_controller: a randomised transmitter responder
// captures every handshaked byte; an item-level model lists the bytes each
// scenario must produce, in order.
module tb_uart_transmitter_controller;

  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   overrun_cnt = 0;
  bit   resp_on = 1'b0;
  bit   resp_active = 1'b0;
  logic [DW-1:0] rx_q [$];
  logic [DW-1:0] exp_q [$];

  uart_transmitter_controller_if #(.DATA_WIDTH(DW)) bus ();

  uart_transmitter_controller #(
    .DATA_WIDTH        (DW),
    .ACK_TIMEOUT_CYCLES(64)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.overrun === 1'b1) overrun_cnt++;

  initial begin
    #500_000;
    $display("FAIL watchdog: got no completion, required completion before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: the bytes one item contributes, in transmission order.
  task automatic expect_rd(input logic [DW-1:0] v);
    exp_q.push_back(v);
  endtask

  task automatic expect_alu(input logic [2*DW-1:0] v);
    exp_q.push_back(v[DW-1:0]);
    exp_q.push_back(v[2*DW-1:DW]);
  endtask

  // Transmitter stand-in: random ack delay, random busy length.
  logic [DW-1:0] first_data;
  initial begin
    bus.transmitter_busy_synchronized = 1'b0;
    forever begin
      @(negedge clk);
      if (resp_on && bus.transmitter_parallel_data_valid && !bus.transmitter_busy_synchronized) begin
        resp_active = 1'b1;
        first_data  = bus.transmitter_parallel_data;
        repeat ($urandom_range(0, 3)) begin
          @(negedge clk);
          check("valid_hold", 32'(bus.transmitter_parallel_data_valid), 32'd1);
          check("data_hold", 32'(bus.transmitter_parallel_data), 32'(first_data));
        end
        rx_q.push_back(first_data);
        bus.transmitter_busy_synchronized = 1'b1;
        @(negedge clk);
        check("valid_drop", 32'(bus.transmitter_parallel_data_valid), 32'd0);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        bus.transmitter_busy_synchronized = 1'b0;
        resp_active = 1'b0;
      end
    end
  end

  task automatic pulse(input bit rv, input logic [DW-1:0] rd, input bit av,
                       input logic [2*DW-1:0] alu);
    @(negedge clk);
    bus.read_data_valid  = rv;
    bus.read_data        = rd;
    bus.ALU_result_valid = av;
    bus.ALU_result       = alu;
    @(negedge clk);
    bus.read_data_valid  = 1'b0;
    bus.ALU_result_valid = 1'b0;
  endtask

  // Called just after pulse() from idle: valid must appear after the second
  // edge following the sampling edge.
  task automatic check_latency(input string tag);
    check({tag, "_busy_n0"}, 32'(bus.controller_busy), 32'd1);
    check({tag, "_valid_n0"}, 32'(bus.transmitter_parallel_data_valid), 32'd0);
    @(negedge clk);
    check({tag, "_valid_n1"}, 32'(bus.transmitter_parallel_data_valid), 32'd0);
    @(negedge clk);
    check({tag, "_valid_n2"}, 32'(bus.transmitter_parallel_data_valid), 32'd1);
    check({tag, "_data_n2"}, 32'(bus.transmitter_parallel_data), 32'(exp_q[0]));
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (n < 1000 && (bus.controller_busy || bus.transmitter_parallel_data_valid ||
                        bus.transmitter_busy_synchronized || resp_active)) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_reached_idle"}, 32'(n < 1000), 32'd1);
    repeat (2) @(negedge clk);
    check({tag, "_busy_low"}, 32'(bus.controller_busy), 32'd0);
  endtask

  task automatic compare_rx(input string tag);
    check({tag, "_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [DW-1:0]   rd;
    logic [2*DW-1:0] alu;
    int              kind, win, cnt;

    reset                = 1'b0;
    bus.enable           = 1'b0;
    bus.read_data        = '0;
    bus.read_data_valid  = 1'b0;
    bus.ALU_result       = '0;
    bus.ALU_result_valid = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_data", 32'(bus.transmitter_parallel_data), 32'd0);
    check("rst_valid", 32'(bus.transmitter_parallel_data_valid), 32'd0);
    check("rst_busy", 32'(bus.controller_busy), 32'd0);
    check("rst_overrun", 32'(bus.overrun), 32'd0);
    reset      = 1'b1;
    bus.enable = 1'b1;
    resp_on    = 1'b1;

    // Single read byte.
    expect_rd(8'h5A);
    overrun_cnt = 0;
    pulse(1'b1, 8'h5A, 1'b0, '0);
    check_latency("rd5a");
    wait_idle("rd5a");
    compare_rx("rd5a");

    // ALU result, low byte first.
    expect_alu(16'hBEEF);
    pulse(1'b0, '0, 1'b1, 16'hBEEF);
    check_latency("alubeef");
    wait_idle("alubeef");
    compare_rx("alubeef");

    // Simultaneous arrivals: read data first.
    expect_rd(8'h12);
    expect_alu(16'h3456);
    pulse(1'b1, 8'h12, 1'b1, 16'h3456);
    check_latency("both");
    wait_idle("both");
    compare_rx("both");
    check("both_overrun", 32'(overrun_cnt), 32'd0);

    // Read buffer overwritten while waiting behind an ALU transfer.
    expect_alu(16'hC3A5);
    expect_rd(8'h77);
    overrun_cnt = 0;
    pulse(1'b0, '0, 1'b1, 16'hC3A5);
    pulse(1'b1, 8'h11, 1'b0, '0);
    pulse(1'b1, 8'h77, 1'b0, '0);
    wait_idle("ovr");
    compare_rx("ovr");
    check("ovr_pulses", 32'(overrun_cnt), 32'd1);

    // New ALU value during its own transmission goes out after the old one.
    expect_alu(16'h1234);
    expect_alu(16'h5678);
    pulse(1'b0, '0, 1'b1, 16'h1234);
    @(negedge clk);
    pulse(1'b0, '0, 1'b1, 16'h5678);
    wait_idle("shadow");
    compare_rx("shadow");

    // Pulse with enable low is ignored.
    bus.enable = 1'b0;
    pulse(1'b1, 8'h99, 1'b1, 16'h9999);
    repeat (3) @(negedge clk);
    check("dis_busy", 32'(bus.controller_busy), 32'd0);
    bus.enable = 1'b1;
    repeat (4) @(negedge clk);
    check("dis_valid", 32'(bus.transmitter_parallel_data_valid), 32'd0);
    check("dis_rx", 32'(rx_q.size()), 32'd0);

    // Reset asserted while waiting for the acknowledge.
    resp_on = 1'b0;
    expect_rd(8'h3C);
    pulse(1'b1, 8'h3C, 1'b0, '0);
    check_latency("rstmid");
    repeat (3) @(negedge clk);
    check("rstmid_held", 32'(bus.transmitter_parallel_data_valid), 32'd1);
    reset = 1'b0;
    #1;
    check("rstmid_valid", 32'(bus.transmitter_parallel_data_valid), 32'd0);
    check("rstmid_busy", 32'(bus.controller_busy), 32'd0);
    check("rstmid_data", 32'(bus.transmitter_parallel_data), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("rstmid_after_valid", 32'(bus.transmitter_parallel_data_valid), 32'd0);
    check("rstmid_after_busy", 32'(bus.controller_busy), 32'd0);
    exp_q.delete();
    rx_q.delete();

`ifdef UART_TX_CTRL_ACK_TIMEOUT_EN
    // No acknowledge: valid held 64 cycles, then the item is dropped.
    expect_rd(8'h42);
    pulse(1'b1, 8'h42, 1'b0, '0);
    check_latency("tmo");
    cnt = 0;
    while (bus.transmitter_parallel_data_valid && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    check("tmo_len", 32'(cnt), 32'd64);
    check("tmo_busy", 32'(bus.controller_busy), 32'd0);
    repeat (3) @(negedge clk);
    check("tmo_stays_idle", 32'(bus.transmitter_parallel_data_valid), 32'd0);
    exp_q.delete();
    rx_q.delete();
`endif
    resp_on = 1'b1;

    // Randomised items, random ack timing, enable dropped mid-transaction.
    for (int it = 0; it < 30; it++) begin
      kind = $urandom_range(0, 2);
      rd   = 8'($urandom);
      alu  = 16'($urandom);
      if (kind != 1) expect_rd(rd);
      if (kind != 0) expect_alu(alu);
      overrun_cnt = 0;
      pulse(kind != 1, rd, kind != 0, alu);
      check_latency($sformatf("rnd%0d", it));
      win = $urandom_range(0, 6);
      if (win > 0) begin
        bus.enable = 1'b0;
        pulse(1'b1, 8'($urandom), 1'b1, 16'($urandom));
        repeat (win - 1) @(negedge clk);
        bus.enable = 1'b1;
      end
      wait_idle($sformatf("rnd%0d", it));
      compare_rx($sformatf("rnd%0d", it));
      check($sformatf("rnd%0d_overrun", it), 32'(overrun_cnt), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
